// File: rtl/tdm_demux4_rx.sv
// Receive side of a 4-slot TDM serial link: deserialises MSB-first slots
// into four parallel channel registers, framed by frame_sync.
module tdm_demux4_rx #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         g,
  input  logic         bit_en,
  input  logic         din,
  input  logic         frame_sync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic [3:0]   ch_valid,
  output logic         frame_done,
  output logic         sync_err
);

  localparam int unsigned CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     ch_q [4];
  logic [W-1:0]     ch_d [4];
  logic [3:0]       valid_d;
  logic             done_d;
  logic             err_d;
  logic [W-1:0]     word;

  // Word formed by shifting the current bit into the slot register
  assign word = {shreg_q[W-2:0], din};

  assign ch0 = ch_q[0];
  assign ch1 = ch_q[1];
  assign ch2 = ch_q[2];
  assign ch3 = ch_q[3];

  // Next-state and next-output logic; pulses default low, everything else holds
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    slot_d    = slot_q;
    shreg_d   = shreg_q;
    ch_d      = ch_q;
    valid_d   = 4'b0000;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (frame_sync) begin
            state_d   = RECV;
            shreg_d   = word;
            bit_cnt_d = CNT_W'(1);
            slot_d    = 2'd0;
          end
        end
        RECV: begin
          if (frame_sync) begin
            // Early sync: drop the partial slot and restart at bit 0 of slot 0
            err_d     = 1'b1;
            shreg_d   = {{(W-1){1'b0}}, din};
            bit_cnt_d = CNT_W'(1);
            slot_d    = 2'd0;
          end else begin
            shreg_d = word;
            if (bit_cnt_q == LAST_BIT) begin
              ch_d[slot_q]    = word;
              valid_d[slot_q] = 1'b1;
              bit_cnt_d       = '0;
              if (slot_q == 2'd3) begin
                done_d  = 1'b1;
                slot_d  = 2'd0;
                state_d = IDLE;
              end else begin
                slot_d = slot_q + 2'd1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; rst or the active-low enable being high clears all
  always_ff @(posedge clk) begin
    if (rst || g) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      slot_q     <= 2'd0;
      shreg_q    <= '0;
      ch_q[0]    <= '0;
      ch_q[1]    <= '0;
      ch_q[2]    <= '0;
      ch_q[3]    <= '0;
      ch_valid   <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_q     <= slot_d;
      shreg_q    <= shreg_d;
      ch_q       <= ch_d;
      ch_valid   <= valid_d;
      frame_done <= done_d;
      sync_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// Bench for tdm_demux4_rx: directed scenarios plus random frames, checked each
// cycle against a frame-position model of the TDM receiver.
`timescale 1ns/1ps
module tb_tdm_demux4_rx;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, g, bit_en, din, frame_sync;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic [3:0]   ch_valid;
  logic         frame_done, sync_err;

  tdm_demux4_rx #(.W(W)) dut (
    .clk(clk), .rst(rst), .g(g), .bit_en(bit_en), .din(din),
    .frame_sync(frame_sync), .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .ch_valid(ch_valid), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;
    logic g;
    logic be;
    logic d;
    logic fs;
  } cyc_t;

  cyc_t stim[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: position within the frame, running word, channel contents
  logic [W-1:0] m_ch [4];
  logic [3:0]   m_valid;
  logic         m_done, m_err, m_in;
  int           m_pos, m_acc;

  task automatic model_step(input cyc_t c);
    int s;
    m_valid = 4'b0000;
    m_done  = 1'b0;
    m_err   = 1'b0;
    if (c.rst || c.g) begin
      for (int k = 0; k < 4; k++) m_ch[k] = '0;
      m_in = 1'b0; m_pos = 0; m_acc = 0;
    end else if (c.be) begin
      if (!m_in) begin
        if (c.fs) begin m_in = 1'b1; m_pos = 1; m_acc = int'(c.d); end
      end else if (c.fs) begin
        m_err = 1'b1; m_pos = 1; m_acc = int'(c.d);
      end else begin
        m_acc = ((m_acc << 1) | int'(c.d)) & ((1 << W) - 1);
        m_pos++;
        if (m_pos % W == 0) begin
          s = m_pos / W - 1;
          m_ch[s]    = W'(m_acc);
          m_valid[s] = 1'b1;
          if (s == 3) begin m_done = 1'b1; m_in = 1'b0; m_pos = 0; end
        end
      end
    end
  endtask

  function automatic logic [4*W+5:0] dut_vec();
    return {ch0, ch1, ch2, ch3, ch_valid, frame_done, sync_err};
  endfunction

  function automatic logic [4*W+5:0] exp_vec();
    return {m_ch[0], m_ch[1], m_ch[2], m_ch[3], m_valid, m_done, m_err};
  endfunction

  // Drive one clock of stimulus, then advance the model past the same edge
  task automatic run_cycle(input cyc_t c);
    rst = c.rst; g = c.g; bit_en = c.be; din = c.d; frame_sync = c.fs;
    @(posedge clk);
    #1;
    model_step(c);
  endtask

  task automatic push(input logic r, input logic gg, input logic be, input logic d, input logic fs);
    cyc_t c;
    c.rst = r; c.g = gg; c.be = be; c.d = d; c.fs = fs;
    stim.push_back(c);
  endtask

  task automatic push_word(input logic [W-1:0] w, input logic sync, input int gap);
    for (int b = W - 1; b >= 0; b--) begin
      push(1'b0, 1'b0, 1'b1, w[b], sync && (b == W - 1));
      for (int k = 0; k < gap; k++) push(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic push_frame(input logic [4*W-1:0] f, input int gap);
    push_word(f[4*W-1 -: W], 1'b1, gap);
    push_word(f[3*W-1 -: W], 1'b0, gap);
    push_word(f[2*W-1 -: W], 1'b0, gap);
    push_word(f[W-1 -: W],   1'b0, gap);
  endtask

  task automatic test_reset();
    stim.delete();
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    foreach (stim[i]) begin
      run_cycle(stim[i]);
      n_cmp++;
      if (dut_vec() !== '0) begin
        n_fail++;
        $display("FAIL test_reset cyc %0d: got %h want 0", i, dut_vec());
      end
    end
  endtask

  task automatic test_frame_slow();
    int vcnt [4];
    int dcnt;
    for (int k = 0; k < 4; k++) vcnt[k] = 0;
    dcnt = 0;
    stim.delete();
    push_frame(16'hA5F0, 2);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (stim[i]) begin
      run_cycle(stim[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL frame_slow cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      for (int k = 0; k < 4; k++) if (ch_valid[k]) vcnt[k]++;
      if (frame_done) begin
        dcnt++;
        n_cmp++;
        if (ch_valid !== 4'b1000) begin
          n_fail++;
          $display("FAIL frame_slow done_coincident: ch_valid %b want 1000", ch_valid);
        end
      end
    end
    n_cmp++;
    if ({ch0, ch1, ch2, ch3} !== 16'hA5F0) begin
      n_fail++;
      $display("FAIL frame_slow channels: got %h want a5f0", {ch0, ch1, ch2, ch3});
    end
    n_cmp++;
    if (vcnt[0] != 1 || vcnt[1] != 1 || vcnt[2] != 1 || vcnt[3] != 1 || dcnt != 1) begin
      n_fail++;
      $display("FAIL frame_slow pulse_counts: got %0d%0d%0d%0d done %0d want 1111 done 1",
               vcnt[0], vcnt[1], vcnt[2], vcnt[3], dcnt);
    end
  endtask

  task automatic test_frame_fast();
    int pidx[$];
    stim.delete();
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_frame(16'hA5F0, 0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (stim[i]) begin
      run_cycle(stim[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL frame_fast cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (ch_valid != 4'b0000) pidx.push_back(i);
    end
    n_cmp++;
    if ({ch0, ch1, ch2, ch3} !== 16'hA5F0 || pidx.size() != 4) begin
      n_fail++;
      $display("FAIL frame_fast result: ch %h pulses %0d want a5f0 pulses 4",
               {ch0, ch1, ch2, ch3}, pidx.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        n_cmp++;
        if (pidx[k] - pidx[k-1] != int'(W)) begin
          n_fail++;
          $display("FAIL frame_fast spacing %0d: got %0d want %0d", k, pidx[k] - pidx[k-1], W);
        end
      end
    end
  endtask

  task automatic test_no_sync();
    stim.delete();
    for (int k = 0; k < 10; k++) push(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
    push_frame(16'h3C96, 1);
    foreach (stim[i]) begin
      run_cycle(stim[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL no_sync cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == 9) begin
        n_cmp++;
        if ({ch0, ch1, ch2, ch3} !== 16'hA5F0) begin
          n_fail++;
          $display("FAIL no_sync hold: got %h want a5f0", {ch0, ch1, ch2, ch3});
        end
      end
    end
    n_cmp++;
    if ({ch0, ch1, ch2, ch3} !== 16'h3C96) begin
      n_fail++;
      $display("FAIL no_sync channels: got %h want 3c96", {ch0, ch1, ch2, ch3});
    end
  endtask

  task automatic test_sync_err();
    logic [15:0] f;
    logic [15:0] first;
    int ecnt;
    f = 16'($urandom);
    first = 16'h1234;
    ecnt = 0;
    stim.delete();
    for (int b = 15; b > 9; b--) push(1'b0, 1'b0, 1'b1, first[b], b == 15);
    push_frame(f, 1);
    foreach (stim[i]) begin
      run_cycle(stim[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sync_err cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (sync_err) begin
        ecnt++;
        n_cmp++;
        if (ch1 !== 4'hC || ch_valid !== 4'b0000) begin
          n_fail++;
          $display("FAIL sync_err ch1_hold: ch1 %h valid %b want c 0000", ch1, ch_valid);
        end
      end
    end
    n_cmp++;
    if (ecnt != 1 || {ch0, ch1, ch2, ch3} !== f) begin
      n_fail++;
      $display("FAIL sync_err result: errs %0d ch %h want 1 %h", ecnt, {ch0, ch1, ch2, ch3}, f);
    end
  endtask

  task automatic test_gate();
    logic [15:0] f;
    int gidx;
    f = 16'($urandom);
    stim.delete();
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_word(4'hA, 1'b1, 1);
    push_word(4'h5, 1'b0, 1);
    push(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    gidx = stim.size() + 1;
    push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push_frame(f, 0);
    foreach (stim[i]) begin
      run_cycle(stim[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL gate cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == gidx - 2) begin
        n_cmp++;
        if ({ch0, ch1} !== 8'hA5) begin
          n_fail++;
          $display("FAIL gate pre: got %h want a5", {ch0, ch1});
        end
      end
      if (i == gidx) begin
        n_cmp++;
        if (dut_vec() !== '0) begin
          n_fail++;
          $display("FAIL gate clear: got %h want 0", dut_vec());
        end
      end
    end
    n_cmp++;
    if ({ch0, ch1, ch2, ch3} !== f) begin
      n_fail++;
      $display("FAIL gate after: got %h want %h", {ch0, ch1, ch2, ch3}, f);
    end
  endtask

  task automatic test_rst_last();
    int dcnt;
    dcnt = 0;
    stim.delete();
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_frame(16'h7E81, 0);
    stim[stim.size() - 1].rst = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (stim[i]) begin
      run_cycle(stim[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_last cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (frame_done) dcnt++;
    end
    n_cmp++;
    if (dut_vec() !== '0 || dcnt != 0) begin
      n_fail++;
      $display("FAIL rst_last clear: got %h done %0d want 0 done 0", dut_vec(), dcnt);
    end
  endtask

  task automatic test_random();
    stim.delete();
    for (int fr = 0; fr < 8; fr++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int k = 0; k < int'($urandom_range(0, 4)); k++)
        push(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) push(1'b0, 1'b1, 1'b1, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < int'($urandom_range(1, 13)); b++)
          push(1'b0, 1'b0, 1'b1, 1'($urandom), b == 0);
      end
      push_frame(16'($urandom), gap);
    end
    foreach (stim[i]) begin
      run_cycle(stim[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; g = 1'b0; bit_en = 1'b0; din = 1'b0; frame_sync = 1'b0;
    for (int k = 0; k < 4; k++) m_ch[k] = '0;
    m_valid = '0; m_done = 1'b0; m_err = 1'b0; m_in = 1'b0; m_pos = 0; m_acc = 0;
    test_reset();
    test_frame_slow();
    test_frame_fast();
    test_no_sync();
    test_sync_err();
    test_gate();
    test_rst_last();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
